disp_stream_out_buffer: RTL

Output buffer placed directly downstream of the stereovision top-level display mux (m_axis_disp_*). That mux is push-only and ignores tready, so this block absorbs it into a FIFO and presents a standard tready-honouring AXI4-Stream master to the VDMA/video-out path. It keeps frames aligned to tuser (SOF). On overflow it drops the rest of the frame, and it checks line length against the configured beat count.

---
 rtl/disp_stream_out_buffer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/disp_stream_out_buffer.sv
// Elastic output buffer behind the push-only display mux: frame-aligned FIFO with a
// registered AXI4-Stream master, overflow frame dropping and a per-line beat checker.
module disp_stream_out_buffer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH       = 512,
  parameter int LINE_BEATS       = 960,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              s_axis_tvalid,
  input  logic [3*AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                              s_axis_tuser,
  input  logic                              s_axis_tlast,
  output logic                              m_axis_tvalid,
  output logic [3*AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic                              m_axis_tuser,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  input  logic                              clear_status,
  output logic                              overflow_flag,
  output logic                              line_err_flag,
  output logic [CNT_WIDTH-1:0]              drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

  localparam int DW = 3 * AXIS_TDATA_WIDTH;
  localparam int EW = DW + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(LINE_BEATS + 1) + 1;

  localparam logic [LW-1:0]        FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0]        LINE_LEN   = BW'(LINE_BEATS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    PASS     = 2'd1,
    DROP     = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [EW-1:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [LW-1:0]   mem_cnt_r;
  logic [BW-1:0]   beat_cnt_r;
  logic [BW-1:0]   cnt_base_s;
  logic [BW-1:0]   cnt_inc_s;
  logic            pop_s;
  logic            room_s;
  logic            sof_s;
  logic            push_s;
  logic            load_s;
  logic            ovf_set_s;
  logic            drop_inc_s;
  logic            line_err_set_s;

  assign pop_s  = m_axis_tvalid && m_axis_tready;
  assign room_s = (fifo_level < FULL_LEVEL) || pop_s;
  assign sof_s  = s_axis_tvalid && s_axis_tuser;
  // The output register refills from storage whenever it is empty or being consumed.
  assign load_s = (mem_cnt_r != {LW{1'b0}}) && (!m_axis_tvalid || pop_s);

  // Frame-alignment decisions: which beats are pushed, lost or dropped.
  always_comb begin
    push_s      = 1'b0;
    ovf_set_s   = 1'b0;
    drop_inc_s  = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      PASS: begin
        if (s_axis_tvalid && room_s) begin
          push_s = 1'b1;
        end else if (s_axis_tvalid) begin
          ovf_set_s   = 1'b1;
          drop_inc_s  = 1'b1;
          state_nxt_s = DROP;
        end else begin
          push_s = 1'b0;
        end
      end
      WAIT_SOF, DROP: begin
        if (sof_s && room_s) begin
          push_s      = 1'b1;
          state_nxt_s = PASS;
        end else if (sof_s) begin
          drop_inc_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = WAIT_SOF;
      end
    endcase
  end

  // Line-length check on pushed beats; a tuser beat opens a fresh line.
  always_comb begin
    cnt_base_s     = s_axis_tuser ? {BW{1'b0}} : beat_cnt_r;
    cnt_inc_s      = cnt_base_s + BW'(1'b1);
    line_err_set_s = 1'b0;
    if (push_s && s_axis_tlast) begin
      line_err_set_s = (cnt_inc_s != LINE_LEN);
    end else if (push_s) begin
      line_err_set_s = (cnt_inc_s == LINE_LEN);
    end else begin
      line_err_set_s = 1'b0;
    end
  end

  // Storage array write port (no reset needed: contents are qualified by mem_cnt_r).
  always_ff @(posedge aclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    end
  end

  // FSM state, storage pointers and storage occupancy.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r   <= WAIT_SOF;
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      mem_cnt_r <= {LW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, load_s})
        2'b10:   mem_cnt_r <= mem_cnt_r + LW'(1'b1);
        2'b01:   mem_cnt_r <= mem_cnt_r - LW'(1'b1);
        default: mem_cnt_r <= mem_cnt_r;
      endcase
    end
  end

  // Registered AXI4-Stream master stage; payload holds while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= {DW{1'b0}};
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (load_s) begin
      m_axis_tvalid <= 1'b1;
      {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= mem_r[rd_ptr_r];
    end else if (pop_s) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Total occupancy: storage plus output register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_level <= {LW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   fifo_level <= fifo_level + LW'(1'b1);
        2'b01:   fifo_level <= fifo_level - LW'(1'b1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Running beat count within the current line.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt_r <= {BW{1'b0}};
    end else if (push_s && s_axis_tlast) begin
      beat_cnt_r <= {BW{1'b0}};
    end else if (push_s) begin
      beat_cnt_r <= cnt_inc_s;
    end
  end

  // Sticky status; clear_status wins over a simultaneous set.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      overflow_flag <= 1'b0;
      line_err_flag <= 1'b0;
      drop_cnt      <= {CNT_WIDTH{1'b0}};
    end else if (clear_status) begin
      overflow_flag <= 1'b0;
      line_err_flag <= 1'b0;
      drop_cnt      <= {CNT_WIDTH{1'b0}};
    end else begin
      if (ovf_set_s) begin
        overflow_flag <= 1'b1;
      end
      if (line_err_set_s) begin
        line_err_flag <= 1'b1;
      end
      if (drop_inc_s && (drop_cnt != CNT_MAX)) begin
        drop_cnt <= drop_cnt + CNT_WIDTH'(1'b1);
      end
    end
  end

endmodule
